// File: rtl/inst_ram_responder_pkg.sv
// ---------------------------------------------------------------------------
// inst_ram_responder_pkg
// Shared constants for the instruction RAM responder and its byte packer:
// instruction bus widths, the zero word, chip-enable polarity, loader byte
// width and the loader FSM state codes.
// ---------------------------------------------------------------------------
package inst_ram_responder_pkg;

    localparam int INST_ADDR_BUS_W = 32;            // InstAddrBus width
    localparam int INST_BUS_W      = 32;            // InstBus width
    localparam int LOADER_BYTE_W   = 8;             // loader byte width
    localparam int BYTES_PER_WORD  = INST_BUS_W / LOADER_BYTE_W;

    localparam logic [INST_BUS_W-1:0] ZERO_WORD = '0;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/inst_ram_responder_byte_word_packer.sv
// ---------------------------------------------------------------------------
// inst_ram_responder_byte_word_packer
// Collects loader bytes into a 32-bit word, most significant byte first.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   clr_i        restart the byte count at the beginning of a load
//   in_valid_i   incoming byte is valid
//   in_ready_i   owner is willing to take a byte this cycle
//   in_byte_i    incoming byte
//   word_valid_o high in the cycle whose accepted byte completes a word
//   word_out_o   assembled word (complete from the cycle after word_valid_o)
// ---------------------------------------------------------------------------
module inst_ram_responder_byte_word_packer
    import inst_ram_responder_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     in_valid_i,
    input  logic                     in_ready_i,
    input  logic [LOADER_BYTE_W-1:0] in_byte_i,
    output logic                     word_valid_o,
    output logic [INST_BUS_W-1:0]    word_out_o
);

    logic [1:0]            bcnt_q, bcnt_d;
    logic [INST_BUS_W-1:0] shift_q, shift_d;
    logic                  accept;

    assign accept = in_valid_i & in_ready_i;

    always_comb begin
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        if (clr_i) begin
            bcnt_d = 2'd0;
        end else if (accept) begin
            // Earlier bytes move up, so the first byte ends in bits 31:24.
            shift_d = {shift_q[INST_BUS_W-LOADER_BYTE_W-1:0], in_byte_i};
            // Two-bit counter wraps to zero after the fourth byte.
            bcnt_d  = bcnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q  <= 2'd0;
            shift_q <= '0;
        end else begin
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid_o = accept && (bcnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_out_o   = shift_q;

endmodule

// File: rtl/inst_ram_responder.sv
// ---------------------------------------------------------------------------
// inst_ram_responder
// Instruction fetch responder backed by a writable word array. Fetches are
// combinational (ROM timing). A byte-serial loader fills the array and holds
// the core in reset while loading.
//
// Ports:
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   ce, addr    fetch enable and byte address from the core
//   inst        instruction word (zero when disabled or out of range)
//   ld_start    one-cycle pulse starting a load of ld_words words
//   ld_words    word count, sampled with ld_start
//   ld_valid, ld_byte, ld_ready   byte stream handshake, big-endian words
//   ld_done     one-cycle pulse after the last word is written
//   ld_busy     load in progress
//   cpu_rst_o   core reset request while loading
// ---------------------------------------------------------------------------
module inst_ram_responder
    import inst_ram_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LEN_W      = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic [INST_ADDR_BUS_W-1:0] addr,
    output logic [INST_BUS_W-1:0]      inst,
    input  logic                       ld_start,
    input  logic [LEN_W-1:0]           ld_words,
    input  logic                       ld_valid,
    input  logic [LOADER_BYTE_W-1:0]   ld_byte,
    output logic                       ld_ready,
    output logic                       ld_done,
    output logic                       ld_busy,
    output logic                       cpu_rst_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    ld_state_e             state_q, state_d;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      wcnt_q;
    logic [INST_BUS_W-1:0] mem [DEPTH];
    logic                  load_accept;
    logic                  word_valid;
    logic [INST_BUS_W-1:0] word;
    logic                  last_word;

    // ld_start is honoured only from IDLE; a pulse during a load is ignored.
    assign load_accept = (state_q == ST_IDLE) && ld_start;
    assign last_word   = (wcnt_q + LEN_W'(1)) == len_q;

    inst_ram_responder_byte_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (load_accept),
        .in_valid_i   (ld_valid),
        .in_ready_i   (ld_ready),
        .in_byte_i    (ld_byte),
        .word_valid_o (word_valid),
        .word_out_o   (word)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d = (ld_words == '0) ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (word_valid) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = last_word ? ST_DONE : ST_RECV;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: the core stays in reset for every non-IDLE state, which makes
    // ld_busy/cpu_rst_o fall on the edge after the DONE cycle.
    always_comb begin
        ld_ready  = (state_q == ST_RECV);
        ld_done   = (state_q == ST_DONE);
        ld_busy   = (state_q != ST_IDLE);
        cpu_rst_o = (state_q != ST_IDLE);
    end

    // Length latch and word counter. The counter is wider than the array
    // index so the length compare still works once the index wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q  <= '0;
            wcnt_q <= '0;
        end else if (load_accept) begin
            len_q  <= ld_words;
            wcnt_q <= '0;
        end else if (state_q == ST_WRITE) begin
            wcnt_q <= wcnt_q + LEN_W'(1);
        end
    end

    // Array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_WRITE) begin
            mem[wcnt_q[DEPTH_LOG2-1:0]] <= word;
        end
    end

    // Fetch path: zero latency; a same-cycle write becomes visible next cycle.
    logic [DEPTH_LOG2-1:0] fetch_idx;
    logic                  addr_in_range;
    logic                  unused_addr_lsbs;

    assign fetch_idx        = addr[DEPTH_LOG2+1:2];
    assign addr_in_range    = (addr[INST_ADDR_BUS_W-1:DEPTH_LOG2+2] == '0);
    assign unused_addr_lsbs = ^addr[1:0];

    always_comb begin
        inst = ZERO_WORD;
        if ((ce == CHIP_ENABLE) && addr_in_range) begin
            inst = mem[fetch_idx];
        end
    end

endmodule

// File: tb/tb_inst_ram_responder.sv
module tb_inst_ram_responder;

    localparam int DEPTH_LOG2 = 10;
    localparam int LEN_W      = 11;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ce = 1'b0;
    logic [31:0]       addr = '0;
    logic [31:0]       inst;
    logic              ld_start = 1'b0;
    logic [LEN_W-1:0]  ld_words = '0;
    logic              ld_valid = 1'b0;
    logic [7:0]        ld_byte = '0;
    logic              ld_ready, ld_done, ld_busy, cpu_rst_o;

    always #5 clk = ~clk;

    inst_ram_responder #(.DEPTH_LOG2(DEPTH_LOG2), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
        .ld_start(ld_start), .ld_words(ld_words), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_ready(ld_ready), .ld_done(ld_done),
        .ld_busy(ld_busy), .cpu_rst_o(cpu_rst_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_count = 0;
    int last_done_cyc = -1;
    bit rand_fetch = 1'b0;

    // Behavioural model: a load is a count of accepted bytes; every fourth
    // byte is followed by one write slot, and after the last word one done slot.
    bit          m_active = 0;
    bit          m_wr_pending = 0;
    bit          m_done_pending = 0;
    int          m_len = 0;
    int          m_bytes = 0;
    logic [31:0] m_asm = '0;
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_fetch(input logic c, input logic [31:0] a, output logic [31:0] v);
        int idx;
        v = 32'h0;
        if (!c) return 1'b1;
        if (a >= 32'(DEPTH * 4)) return 1'b1;
        idx = int'(a / 4);
        v = m_mem[idx];
        return m_known[idx];
    endfunction

    // Model advance on each clock edge.
    always @(posedge clk) begin
        int idx;
        cyc++;
        if (!rst) begin
            if (!m_active) begin
                if (ld_start) begin
                    m_active = 1;
                    m_len = int'(ld_words);
                    m_bytes = 0;
                    m_done_pending = (ld_words == 0);
                end
            end else if (m_done_pending) begin
                m_done_pending = 0;
                m_active = 0;
            end else if (m_wr_pending) begin
                idx = (m_bytes / 4 - 1) % DEPTH;
                m_mem[idx] = m_asm;
                m_known[idx] = 1;
                m_wr_pending = 0;
                if (m_bytes / 4 == m_len) m_done_pending = 1;
            end else if (ld_valid) begin
                m_asm = {m_asm[23:0], ld_byte};
                m_bytes++;
                if (m_bytes % 4 == 0) m_wr_pending = 1;
            end
        end
    end

    // Compare process: all outputs every cycle.
    always @(negedge clk) begin
        logic [31:0] ev;
        bit known;
        if (rst) begin
            m_active = 0; m_wr_pending = 0; m_done_pending = 0; m_bytes = 0;
        end
        chk("ld_ready", ld_ready, m_active && !m_wr_pending && !m_done_pending);
        chk("ld_done", ld_done, m_done_pending);
        chk("ld_busy", ld_busy, m_active);
        chk("cpu_rst_o", cpu_rst_o, m_active);
        known = model_fetch(ce, addr, ev);
        if (known) chk("inst", inst, ev);
        if (ld_done) begin
            done_count++;
            last_done_cyc = cyc;
        end
    end

    // Random fetch traffic when enabled.
    always @(posedge clk) begin
        int r;
        #1;
        if (rand_fetch) begin
            ce = ($urandom_range(9) != 0);
            r = $urandom_range(15);
            if (r == 0) addr = $urandom;
            else addr = {20'd0, 10'($urandom_range(1023)), 2'($urandom_range(3))};
        end
    end

    task automatic fetch_chk(input string name, input logic c, input logic [31:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        ce = c; addr = a;
        @(negedge clk); #1;
        chk(name, inst, exp);
    endtask

    // Drives one load. alternate toggles ld_valid every cycle; otherwise
    // ld_valid is high with probability valid_pct. restart_at injects a
    // stray ld_start before that byte; abort_after resets after that many bytes.
    task automatic run_load(input int nwords, input logic [7:0] bytes[$], input int valid_pct,
                            input bit alternate, input int restart_at, input int abort_after,
                            output int start_c, output int first_acc);
        int idx = 0, budget = 0, done0, waited = 0;
        bit acc, tgl = 1'b1, restarted = 1'b0;
        first_acc = -1;
        done0 = done_count;
        @(posedge clk); #1;
        ld_start = 1'b1; ld_words = LEN_W'(nwords); ld_valid = 1'b0;
        start_c = cyc;
        @(posedge clk); #1;
        ld_start = 1'b0;
        while (idx < bytes.size()) begin
            ld_byte = bytes[idx];
            ld_valid = alternate ? tgl : ($urandom_range(99) < valid_pct);
            tgl = !tgl;
            ld_start = 1'b0;
            if (idx == restart_at && !restarted) begin
                ld_start = 1'b1; ld_words = LEN_W'(7); restarted = 1'b1;
            end
            @(negedge clk);
            acc = ld_valid && ld_ready;
            if (acc && idx == 0) first_acc = cyc;
            @(posedge clk); #1;
            if (acc) idx++;
            if (idx == abort_after) begin
                rst = 1'b1; ld_valid = 1'b0; ld_start = 1'b0;
                @(negedge clk); #1;
                chk("abort_busy", ld_busy, 0);
                chk("abort_cpu_rst", cpu_rst_o, 0);
                chk("abort_ready", ld_ready, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                $display("load: words=%0d aborted by reset after %0d bytes", nwords, idx);
                return;
            end
            budget++;
            if (budget > bytes.size() * 20 + 50) begin
                chk("byte_timeout", 32'(idx), 32'(bytes.size()));
                break;
            end
        end
        ld_valid = 1'b0; ld_start = 1'b0;
        while (done_count == done0 && waited < 100) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("done_seen", 32'(done_count - done0), 1);
        @(negedge clk); #1;
        chk("cpu_rst_after_done", cpu_rst_o, 0);
        chk("busy_after_done", ld_busy, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("done_once", 32'(done_count - done0), 1);
        $display("load: words=%0d bytes=%0d done at cycle %0d", nwords, bytes.size(), last_done_cyc);
    endtask

    initial begin
        logic [7:0] q[$];
        int sc, fa, n;
        logic [31:0] w;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_ready", ld_ready, 0);
        chk("reset_done", ld_done, 0);
        chk("reset_busy", ld_busy, 0);
        chk("reset_cpu_rst", cpu_rst_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        fetch_chk("ce0_addr0", 1'b0, 32'h0, 32'h0);

        // Two-word load with ld_valid held high.
        q = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h3C, 8'h02, 8'h00, 8'h10};
        run_load(2, q, 100, 1'b0, -1, -1, sc, fa);
        chk("done_latency", 32'(last_done_cyc - fa), 10);
        fetch_chk("word0", 1'b1, 32'h0, 32'h34011100);
        fetch_chk("word1", 1'b1, 32'h4, 32'h3C020010);
        fetch_chk("word1_unaligned", 1'b1, 32'h5, 32'h3C020010);
        fetch_chk("out_of_range", 1'b1, 32'h00001000, 32'h0);
        fetch_chk("ce0_word1", 1'b0, 32'h4, 32'h0);

        // Backpressure: ld_valid toggles every cycle.
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(1, q, 0, 1'b1, -1, -1, sc, fa);
        fetch_chk("backpressure_word", 1'b1, 32'h0, 32'h11223344);

        // Zero-length load.
        q.delete();
        run_load(0, q, 100, 1'b0, -1, -1, sc, fa);
        chk("zero_len_done_cycle", 32'(last_done_cyc - sc), 1);
        fetch_chk("zero_len_unchanged", 1'b1, 32'h0, 32'h11223344);

        // Reset after two bytes of word 0, then a fresh load.
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(1, q, 100, 1'b0, -1, 2, sc, fa);
        fetch_chk("reset_word_kept", 1'b1, 32'h0, 32'h11223344);
        q = '{8'h55, 8'h66, 8'h77, 8'h88};
        run_load(1, q, 100, 1'b0, -1, -1, sc, fa);
        fetch_chk("fresh_load_word", 1'b1, 32'h0, 32'h55667788);

        // Stray ld_start mid-load is ignored.
        rand_fetch = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
        run_load(2, q, 80, 1'b0, 3, -1, sc, fa);

        // Random loads.
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 10);
            q.delete();
            for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
            run_load(n, q, $urandom_range(30, 100), 1'b0, -1, -1, sc, fa);
        end

        // Wrap: two words beyond the array size land at index 0 and 1.
        n = DEPTH + 2;
        q.delete();
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
        run_load(n, q, 100, 1'b0, -1, -1, sc, fa);
        rand_fetch = 1'b0;
        w = {q[4 * DEPTH], q[4 * DEPTH + 1], q[4 * DEPTH + 2], q[4 * DEPTH + 3]};
        fetch_chk("wrap_word0", 1'b1, 32'h0, w);
        w = {q[4 * DEPTH + 4], q[4 * DEPTH + 5], q[4 * DEPTH + 6], q[4 * DEPTH + 7]};
        fetch_chk("wrap_word1", 1'b1, 32'h4, w);
        w = {q[8], q[9], q[10], q[11]};
        fetch_chk("wrap_word2", 1'b1, 32'h8, w);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
